// File: rtl/ccff_loader_pkg.sv
// Shared constants for the Wishbone configuration-chain loader: register map,
// CTRL/STAT bit positions and FSM state encodings.
package ccff_loader_pkg;

  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_LEN  = 2'd1;
  localparam logic [1:0] ADR_DATA = 2'd2;
  localparam logic [1:0] ADR_STAT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_PRST  = 2;
  localparam int CTRL_CLR   = 3;

  localparam int STAT_OVF   = 31;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

endpackage

// File: rtl/ccff_word_fifo.sv
// Synchronous 32-bit word FIFO with flush; head word is presented combinationally.
module ccff_word_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [DEPTH-1:0][31:0] mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic                   push_ok, pop_ok;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    empty    = (level_q == '0);
    pop_ok   = pop & ~empty;
    // A pop frees the slot being written, so a full FIFO still accepts a push.
    push_ok  = push & (~full | pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/wb_ccff_loader.sv
// Wishbone slave that streams FIFO'd words MSB-first into the fabric config chain,
// generating prog_clk as a divided data signal and capturing ccff_tail.
module wb_ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV        = 4,
  parameter int CNT_W      = 20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        prog_reset_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        done_irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              req_we_q, req_we_d;
  logic [1:0]        req_adr_q, req_adr_d;
  logic [31:0]       req_dat_q, req_dat_d;
  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  rem_q, rem_d, len_q, len_d;
  logic [31:0]       shreg_q, shreg_d, capt_q, capt_d;
  logic              head_q, head_d, pclk_q, pclk_d, prst_q, prst_d;
  logic              done_q, done_d, ovf_q, ovf_d, irq_q, irq_d;

  logic              req, wr, ctrl_wr, start, abort, busy;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]       fifo_rdata, rd_val;
  logic [LVL_W-1:0]  fifo_level;
  logic              hi_entry, div_last;
  logic [CNT_W-1:0]  rem_n;
  logic [5:0]        bit_n;
  logic              unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  ccff_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (abort),
    .push  (fifo_push),
    .wdata (req_dat_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Request is latched when seen; its side effects land in the ack cycle.
  always_comb begin
    req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
    ack_d     = req;
    req_we_d  = req ? wbs_we_i       : req_we_q;
    req_adr_d = req ? wbs_adr_i[3:2] : req_adr_q;
    req_dat_d = req ? wbs_dat_i      : req_dat_q;
    wr        = ack_q & req_we_q;
    ctrl_wr   = wr && (req_adr_q == ADR_CTRL);
    start     = ctrl_wr & req_dat_q[CTRL_START];
    abort     = ctrl_wr & req_dat_q[CTRL_ABORT];
    busy      = (state_q != S_IDLE);
    fifo_push = wr && (req_adr_q == ADR_DATA);
    fifo_pop  = (state_q == S_LOAD) & ~fifo_empty & ~abort;

    prst_d = ctrl_wr ? req_dat_q[CTRL_PRST] : prst_q;
    len_d  = (wr && (req_adr_q == ADR_LEN) && !busy) ? req_dat_q[CNT_W-1:0] : len_q;
    ovf_d  = ovf_q;
    if (ctrl_wr && req_dat_q[CTRL_CLR]) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    rd_val = '0;
    case (wbs_adr_i[3:2])
      ADR_CTRL: rd_val = {29'd0, prst_q, done_q, busy};
      ADR_LEN:  rd_val = 32'(len_q);
      ADR_DATA: rd_val = capt_q;
      ADR_STAT: rd_val = {ovf_q, 15'd0, 8'(fifo_level), 8'(rem_q)};
      default:  rd_val = '0;
    endcase
    dat_d = (req && !wbs_we_i) ? rd_val : '0;
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    rem_d    = rem_q;
    shreg_d  = shreg_q;
    capt_d   = capt_q;
    head_d   = head_q;
    done_d   = done_q;
    if (ctrl_wr && req_dat_q[CTRL_CLR]) done_d = 1'b0;

    hi_entry = (state_q == S_SHIFT_HI) && (div_q == '0);
    div_last = (div_q == DIV_W'(DIV - 1));
    rem_n    = hi_entry ? rem_q - 1'b1 : rem_q;
    bit_n    = hi_entry ? bit_q + 1'b1 : bit_q;

    case (state_q)
      S_IDLE: if (start) begin
        rem_d   = len_q;
        state_d = (len_q == '0) ? S_FINISH : S_LOAD;
      end
      S_LOAD: if (!fifo_empty) begin
        shreg_d = fifo_rdata;
        head_d  = fifo_rdata[31];
        bit_d   = '0;
        div_d   = '0;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) state_d = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (hi_entry) begin
          capt_d  = {capt_q[30:0], ccff_tail_i};
          shreg_d = {shreg_q[30:0], 1'b0};
          rem_d   = rem_n;
          bit_d   = bit_n;
        end
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          if (rem_n == '0)        state_d = S_FINISH;
          else if (bit_n == 6'd32) state_d = S_LOAD;
          else begin
            state_d = S_SHIFT_LO;
            head_d  = shreg_d[31];
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks start and anything the FSM decided this cycle.
    if (abort) begin
      state_d = S_IDLE;
      rem_d   = '0;
      div_d   = '0;
    end

    pclk_d = (state_d == S_SHIFT_HI);
    irq_d  = (state_d == S_FINISH);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      req_we_q  <= 1'b0;
      req_adr_q <= '0;
      req_dat_q <= '0;
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      shreg_q   <= '0;
      capt_q    <= '0;
      head_q    <= 1'b0;
      pclk_q    <= 1'b0;
      prst_q    <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      req_we_q  <= req_we_d;
      req_adr_q <= req_adr_d;
      req_dat_q <= req_dat_d;
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      shreg_q   <= shreg_d;
      capt_q    <= capt_d;
      head_q    <= head_d;
      pclk_q    <= pclk_d;
      prst_q    <= prst_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign prog_clk_o   = pclk_q;
  assign prog_reset_o = prst_q;
  assign ccff_head_o  = head_q;
  assign done_irq_o   = irq_q;

endmodule

// File: tb/tb_wb_ccff_loader.sv
// Scoreboard bench for wb_ccff_loader: stimulus queues expected read data and
// expected chain bits; a monitor pops and compares as the DUT produces them.
module tb_wb_ccff_loader;

  localparam int DIV = 4;
  localparam logic [1:0] A_CTRL = 2'd0, A_LEN = 2'd1, A_DATA = 2'd2, A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack, pclk, prst, head, tail, irq;
  logic [31:0] dat_o;
  bit          loop_en = 1'b0;

  assign tail = loop_en ? head : 1'b0;

  always #5 clk = ~clk;

  wb_ccff_loader #(.FIFO_DEPTH(8), .DIV(DIV), .CNT_W(20)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_i),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .prog_clk_o   (pclk),
    .prog_reset_o (prst),
    .ccff_head_o  (head),
    .ccff_tail_i  (tail),
    .done_irq_o   (irq)
  );

  int          n_chk = 0, n_fail = 0;
  int          rise_cnt = 0, irq_cnt = 0, cyc_n = 0, ack_cyc = 0, start_ack = 0;
  int          rise_at[$];
  logic [31:0] rd_q[$];
  bit          bit_q[$];
  logic        pclk_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Monitor: read data on read acks, chain bits on prog_clk rises, irq pulses.
  always @(posedge clk) begin
    #1;
    if (ack && !we) begin
      if (rd_q.size() == 0) chk("rd_unexpected", dat_o, 32'hxxxx_xxxx);
      else chk("rd_data", dat_o, rd_q.pop_front());
    end
    if (ack && we) chk("wr_dat_zero", dat_o, 32'd0);
    if (pclk && !pclk_prev) begin
      rise_cnt++;
      rise_at.push_back(cyc_n);
      if (bit_q.size() == 0) chk("rise_unexpected", {31'd0, head}, 32'hxxxx_xxxx);
      else chk("head_bit", {31'd0, head}, {31'd0, bit_q.pop_front()});
    end
    pclk_prev = pclk;
    if (irq) irq_cnt++;
  end

  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dat_i = d;
    do begin @(negedge clk); t++; end while (!ack && t < 8);
    if (!ack) chk("wb_ack_timeout", {31'd0, ack}, 32'd1);
    else ack_cyc = cyc_n;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    xfer(1'b1, a, d);
  endtask

  task automatic wb_rd(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    xfer(1'b0, a, 32'd0);
  endtask

  task automatic exp_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(w[31-i]);
  endtask

  task automatic wait_irq(input int target, input int budget);
    int t;
    t = 0;
    while (irq_cnt < target && t < budget) begin @(negedge clk); t++; end
    chk("wait_irq", irq_cnt, target);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int t;
    t = 0;
    while (rise_cnt < target && t < budget) begin @(negedge clk); t++; end
    chk("wait_rises", rise_cnt, target);
  endtask

  initial begin
    int i0, r0;
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_prog_reset", {31'd0, prst}, 32'd1);
    chk("rst_prog_clk",   {31'd0, pclk}, 32'd0);
    chk("rst_head",       {31'd0, head}, 32'd0);
    chk("rst_ack",        {31'd0, ack},  32'd0);
    chk("rst_irq",        {31'd0, irq},  32'd0);
    chk("rst_dat",        dat_o,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wb_rd(A_STAT, 32'd0);
    wb_rd(A_CTRL, 32'h4);

    // 8-bit load of 0xA5, plus first-rise latency and bit period
    i0 = irq_cnt; r0 = rise_cnt;
    exp_bits(32'hA500_0000, 8);
    wb_wr(A_DATA, 32'hA500_0000);
    wb_wr(A_LEN, 32'd8);
    wb_wr(A_CTRL, 32'h5);
    start_ack = ack_cyc;
    wait_irq(i0 + 1, 300);
    repeat (4) @(negedge clk);
    chk("a5_irq_count", irq_cnt - i0, 1);
    chk("a5_rises", rise_cnt - r0, 8);
    chk("a5_bits_left", bit_q.size(), 0);
    chk("first_rise_latency", rise_at[0] - start_ack, DIV + 2);
    chk("bit_period", rise_at[1] - rise_at[0], 2 * DIV);
    wb_rd(A_CTRL, 32'h6);

    // Loopback, two words, 40 bits
    wb_wr(A_CTRL, 32'hC);
    loop_en = 1'b1;
    i0 = irq_cnt; r0 = rise_cnt;
    exp_bits(32'hFFFF_FFFF, 32);
    exp_bits(32'h8000_0000, 8);
    wb_wr(A_DATA, 32'hFFFF_FFFF);
    wb_wr(A_DATA, 32'h8000_0000);
    wb_wr(A_LEN, 32'd40);
    wb_rd(A_LEN, 32'd40);
    wb_wr(A_CTRL, 32'h5);
    wait_irq(i0 + 1, 800);
    repeat (4) @(negedge clk);
    chk("loop_rises", rise_cnt - r0, 40);
    chk("loop_bits_left", bit_q.size(), 0);
    wb_rd(A_DATA, 32'hFFFF_FF80);
    wb_rd(A_STAT, 32'd0);
    wb_rd(A_CTRL, 32'h6);
    loop_en = 1'b0;

    // FIFO overflow and clear
    for (int i = 0; i < 9; i++) wb_wr(A_DATA, 32'h100 + i);
    wb_rd(A_STAT, 32'h8000_0800);
    wb_wr(A_CTRL, 32'hC);
    wb_rd(A_STAT, 32'h0000_0800);
    wb_wr(A_CTRL, 32'h6);
    wb_rd(A_STAT, 32'd0);
    wb_rd(A_CTRL, 32'h4);

    // Underrun stall, LEN write ignored while busy, resume
    i0 = irq_cnt; r0 = rise_cnt;
    exp_bits(32'h1234_5678, 32);
    wb_wr(A_DATA, 32'h1234_5678);
    wb_wr(A_LEN, 32'd64);
    wb_wr(A_CTRL, 32'h5);
    wait_rises(r0 + 32, 600);
    repeat (3 * DIV + 4) @(negedge clk);
    chk("stall_prog_clk", {31'd0, pclk}, 32'd0);
    chk("stall_rises", rise_cnt - r0, 32);
    wb_rd(A_CTRL, 32'h5);
    wb_rd(A_STAT, 32'h20);
    wb_wr(A_LEN, 32'd7);
    wb_rd(A_LEN, 32'd64);
    exp_bits(32'hCAFE_F00D, 32);
    wb_wr(A_DATA, 32'hCAFE_F00D);
    wait_irq(i0 + 1, 800);
    repeat (4) @(negedge clk);
    chk("stall_total_rises", rise_cnt - r0, 64);
    chk("stall_bits_left", bit_q.size(), 0);
    wb_rd(A_CTRL, 32'h6);

    // Abort at bit 5
    wb_wr(A_CTRL, 32'hC);
    i0 = irq_cnt; r0 = rise_cnt;
    exp_bits(32'hFFFF_0000, 5);
    wb_wr(A_DATA, 32'hFFFF_0000);
    wb_wr(A_LEN, 32'd32);
    wb_wr(A_CTRL, 32'h5);
    wait_rises(r0 + 5, 300);
    wb_wr(A_CTRL, 32'h6);
    @(negedge clk);
    chk("abort_prog_clk", {31'd0, pclk}, 32'd0);
    wb_rd(A_STAT, 32'd0);
    wb_rd(A_CTRL, 32'h4);
    repeat (40) @(negedge clk);
    chk("abort_rises", rise_cnt - r0, 5);
    chk("abort_no_irq", irq_cnt - i0, 0);
    chk("abort_bits_left", bit_q.size(), 0);

    // LEN=0 start: done with no prog_clk activity
    i0 = irq_cnt; r0 = rise_cnt;
    wb_wr(A_LEN, 32'd0);
    wb_wr(A_CTRL, 32'h5);
    wait_irq(i0 + 1, 50);
    repeat (4) @(negedge clk);
    chk("len0_irq_count", irq_cnt - i0, 1);
    chk("len0_rises", rise_cnt - r0, 0);
    wb_rd(A_CTRL, 32'h6);

    chk("reads_outstanding", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
